// File: rtl/icache_tagv_nway_pkg.sv
// Shared types and defaults for the I-cache tag/valid directory.
// Optional stats counters: define ICACHE_TAGV_STATS_EN.
package icache_pkg;

  localparam int DEF_WAYS    = 2;
  localparam int DEF_INDEX_W = 7;
  localparam int DEF_TAG_W   = 20;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entry layout {tag, valid} at default geometry.
  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic                 valid;
  } tagv_t;

  // Way-select width, at least one bit even for a direct-mapped cache.
  function automatic int ways_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_tagv_nway_if.sv
// Control/response bundle between the I-cache FSM and the tag directory.
// Optional stats counters: define ICACHE_TAGV_STATS_EN.
interface icache_tagv_nway_if
  import icache_pkg::*;
#(
  parameter int WAYS    = DEF_WAYS,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
);
  localparam int WAYS_W = ways_w(WAYS);

  logic               ready;
  logic               flush;
  logic               lookup_en;
  logic [INDEX_W-1:0] lookup_idx;
  logic [TAG_W-1:0]   lookup_tag;
  logic               hit;
  logic [WAYS_W-1:0]  hit_way;
  logic [WAYS_W-1:0]  victim_way;
  logic               refill_en;
  logic [INDEX_W-1:0] refill_idx;
  logic [WAYS_W-1:0]  refill_way;
  logic [TAG_W-1:0]   refill_tag;
  logic               inval_en;
  logic [INDEX_W-1:0] inval_idx;
  logic [31:0]        hit_cnt;
  logic [31:0]        miss_cnt;

  modport master (
    output flush, lookup_en, lookup_idx, lookup_tag,
    output refill_en, refill_idx, refill_way, refill_tag,
    output inval_en, inval_idx,
    input  ready, hit, hit_way, victim_way,
    input  hit_cnt, miss_cnt
  );

  modport slave (
    input  flush, lookup_en, lookup_idx, lookup_tag,
    input  refill_en, refill_idx, refill_way, refill_tag,
    input  inval_en, inval_idx,
    output ready, hit, hit_way, victim_way,
    output hit_cnt, miss_cnt
  );

endinterface

// File: rtl/icache_tagv_nway_way.sv
// One way of the directory: tag + valid arrays, registered read.
// Optional stats counters (top only): define ICACHE_TAGV_STATS_EN.
module icache_tagv_way #(
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               i_rd_en,
  input  logic               i_rd_clr,
  input  logic [INDEX_W-1:0] i_rd_idx,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic               i_clr_en,
  input  logic [INDEX_W-1:0] i_clr_idx,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag
);
  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0] r_tag [SETS];
  logic [SETS-1:0]  r_valid;
  logic             r_rd_valid;
  logic [TAG_W-1:0] r_rd_tag;

  // Tag array write; tags survive invalidation.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_tag[i_wr_idx] <= i_wr_tag;
  end

  // Valid bits: clear is issued last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
    if (i_clr_en) r_valid[i_clr_idx] <= 1'b0;
  end

  // Read register sees pre-write contents; holds when idle.
  always_ff @(posedge clk) begin
    if (i_rd_clr) begin
      r_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_valid <= r_valid[i_rd_idx];
      r_rd_tag   <= r_tag[i_rd_idx];
    end
  end

  assign o_valid = r_rd_valid;
  assign o_tag   = r_rd_tag;

endmodule

// File: rtl/icache_tagv_nway.sv
// N-way tag/valid directory: init sweep, lookup, refill, round-robin victim.
// Optional stats counters: define ICACHE_TAGV_STATS_EN.
module icache_tagv_nway
  import icache_pkg::*;
#(
  parameter int WAYS    = DEF_WAYS,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input logic               clk,
  input logic               rst,
  icache_tagv_nway_if.slave bus
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int WAYS_W = ways_w(WAYS);

  state_t             r_state;
  logic [INDEX_W-1:0] r_init_cnt;
  logic               r_ready;
  logic [WAYS_W-1:0]  r_rr [SETS];
  logic [WAYS_W-1:0]  r_lk_rr;
  logic [TAG_W-1:0]   r_lk_tag;

  logic               w_run;
  logic               w_act;
  logic               w_lk;
  logic               w_inval;
  logic               w_refill;
  logic               w_clr_en;
  logic [INDEX_W-1:0] w_clr_idx;
  logic [WAYS_W-1:0]  w_rr_next;
  logic [WAYS-1:0]    w_valid;
  logic [TAG_W-1:0]   w_tag [WAYS];
  logic [WAYS-1:0]    w_match;
  logic               w_hit;
  logic [WAYS_W-1:0]  w_hit_way;
  logic [WAYS_W-1:0]  w_victim;

  assign w_run    = (r_state == ST_RUN);
  assign w_act    = w_run & ~rst & ~bus.flush;
  assign w_lk     = w_act & bus.lookup_en;
  assign w_inval  = w_act & bus.inval_en;
  assign w_refill = w_act & bus.refill_en
                  & ~(w_inval && bus.inval_idx == bus.refill_idx);
  assign w_clr_en  = ~w_run | w_inval;
  assign w_clr_idx = w_run ? bus.inval_idx : r_init_cnt;
  assign w_rr_next =
    WAYS_W'((int'(bus.refill_way) + 1) % WAYS);

  // Init/run FSM; ready is a registered copy of the run state.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == INDEX_W'(SETS - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: ;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Per-set round-robin pointer: swept in init, advanced on refill.
  always_ff @(posedge clk) begin
    if (!w_run) r_rr[r_init_cnt] <= '0;
    else if (w_refill) r_rr[bus.refill_idx] <= w_rr_next;
  end

  // Capture lookup tag and pre-write rr pointer alongside way reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_tag <= '0;
      r_lk_rr  <= '0;
    end else if (w_lk) begin
      r_lk_tag <= bus.lookup_tag;
      r_lk_rr  <= r_rr[bus.lookup_idx];
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_tagv_way #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
    ) u_way (
      .clk       (clk),
      .i_rd_en   (w_lk),
      .i_rd_clr  (rst | bus.flush),
      .i_rd_idx  (bus.lookup_idx),
      .i_wr_en   (w_refill && bus.refill_way == WAYS_W'(g)),
      .i_wr_idx  (bus.refill_idx),
      .i_wr_tag  (bus.refill_tag),
      .i_clr_en  (w_clr_en),
      .i_clr_idx (w_clr_idx),
      .o_valid   (w_valid[g]),
      .o_tag     (w_tag[g])
    );
    assign w_match[g] = w_valid[g] & (w_tag[g] == r_lk_tag);
  end

  // Lowest matching way, lowest empty way, else rr pointer.
  always_comb begin
    w_hit     = |w_match;
    w_hit_way = '0;
    w_victim  = r_lk_rr;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_way = WAYS_W'(i);
      if (!w_valid[i]) w_victim = WAYS_W'(i);
    end
  end

  assign bus.ready      = r_ready;
  assign bus.hit        = w_hit;
  assign bus.hit_way    = w_hit_way;
  assign bus.victim_way = w_victim;

`ifdef ICACHE_TAGV_STATS_EN
  logic        r_lk_done;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Count each completed lookup once its result is on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_done  <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_lk_done <= w_lk;
      if (r_lk_done) begin
        if (w_hit) r_hit_cnt <= r_hit_cnt + 1'b1;
        else r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_tagv_nway.sv
// Directed bench for icache_tagv_nway at default geometry.
// Stats checks follow ICACHE_TAGV_STATS_EN.
module tb_icache_tagv_nway;
  localparam int WAYS    = 2;
  localparam int INDEX_W = 7;
  localparam int TAG_W   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_tagv_nway_if #(
    .WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)
  ) bus ();

  icache_tagv_nway #(
    .WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic               lk;
    logic [INDEX_W-1:0] lidx;
    logic [TAG_W-1:0]   ltag;
    logic               rf;
    logic [INDEX_W-1:0] ridx;
    logic               rway;
    logic [TAG_W-1:0]   rtag;
    logic               iv;
    logic [INDEX_W-1:0] iidx;
    logic               chk;
    logic               hit;
    logic               way;
    logic               vic;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    int lk, int lidx, int ltag, int rf, int ridx, int rway,
    int rtag, int iv, int iidx, int c, int h, int w, int v);
    vec_t x;
    x.lk = lk[0];   x.lidx = lidx[INDEX_W-1:0];
    x.ltag = ltag[TAG_W-1:0];
    x.rf = rf[0];   x.ridx = ridx[INDEX_W-1:0];
    x.rway = rway[0]; x.rtag = rtag[TAG_W-1:0];
    x.iv = iv[0];   x.iidx = iidx[INDEX_W-1:0];
    x.chk = c[0];   x.hit = h[0];
    x.way = w[0];   x.vic = v[0];
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    bus.flush = 0; bus.lookup_en = 0; bus.refill_en = 0;
    bus.inval_en = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(int idx, int tag);
    idle();
    bus.lookup_en = 1;
    bus.lookup_idx = idx[INDEX_W-1:0];
    bus.lookup_tag = tag[TAG_W-1:0];
    step();
  endtask

  task automatic refill(int idx, int way, int tag);
    idle();
    bus.refill_en = 1;
    bus.refill_idx = idx[INDEX_W-1:0];
    bus.refill_way = way[0];
    bus.refill_tag = tag[TAG_W-1:0];
    step();
  endtask

  task automatic lk_chk(string nm, int idx, int tag,
                        int h, int w, int v);
    lookup(idx, tag);
    chk({nm, ".hit"}, bus.hit, h);
    chk({nm, ".way"}, bus.hit_way, w);
    chk({nm, ".vic"}, bus.victim_way, v);
  endtask

  // Called one sample after the INIT-entry edge (ready already 0).
  task automatic wait_ready(string nm);
    int n;
    n = 1;
    idle();
    bus.lookup_en = 1;
    bus.lookup_idx = 5;
    bus.lookup_tag = 20'hABCDE;
    for (int k = 0; k < 400 && !bus.ready; k++) begin
      step();
      chk({nm, ".init_hit"}, bus.hit, 0);
      if (!bus.ready) n++;
    end
    chk({nm, ".ready_low_cycles"}, n, 128);
    idle();
  endtask

  task automatic do_flush(string nm);
    idle();
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk({nm, ".ready0"}, bus.ready, 0);
    chk({nm, ".hit0"}, bus.hit, 0);
    wait_ready(nm);
  endtask

  initial begin
    idle();
    bus.lookup_idx = '0; bus.lookup_tag = '0;
    bus.refill_idx = '0; bus.refill_way = '0;
    bus.refill_tag = '0; bus.inval_idx = '0;
    rst = 1;
    step(); step();
    chk("rst.ready", bus.ready, 0);
    chk("rst.hit", bus.hit, 0);
    chk("rst.hit_way", bus.hit_way, 0);
    chk("rst.victim", bus.victim_way, 0);
    chk("rst.hit_cnt", bus.hit_cnt, 0);
    chk("rst.miss_cnt", bus.miss_cnt, 0);
    rst = 0;
    wait_ready("init");

    // Reset mid-INIT restarts the full sweep.
    repeat (50) step();
    rst = 1;
    step();
    chk("midrst.ready", bus.ready, 0);
    rst = 0;
    repeat (60) step();
    chk("midrst.still_low", bus.ready, 0);
    rst = 1;
    step();
    rst = 0;
    wait_ready("midrst");

    // lk lidx ltag rf ridx rway rtag iv iidx chk hit way vic
    tbl.push_back(mk(0,0,0, 1,5,1,'hABCDE, 0,0, 0,0,0,0));
    tbl.push_back(mk(1,5,'hABCDE, 0,0,0,0, 0,0, 1,1,1,0));
    tbl.push_back(mk(1,9,'h22, 0,0,0,0, 0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,9,0,'h11, 0,0, 0,0,0,0));
    tbl.push_back(mk(1,9,'h22, 0,0,0,0, 0,0, 1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,9,1,'h22, 0,0, 0,0,0,0));
    tbl.push_back(mk(1,9,'h22, 0,0,0,0, 0,0, 1,1,1,0));
    tbl.push_back(mk(1,9,'h11, 0,0,0,0, 0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0, 1,1,0,0));
    tbl.push_back(mk(1,20,'h333, 1,20,0,'h333, 0,0, 1,0,0,0));
    tbl.push_back(mk(1,20,'h333, 0,0,0,0, 0,0, 1,1,0,1));
    tbl.push_back(mk(0,0,0, 1,21,0,'h44, 1,21, 0,0,0,0));
    tbl.push_back(mk(1,21,'h44, 0,0,0,0, 0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,9,0,'h55, 0,0, 0,0,0,0));
    tbl.push_back(mk(1,9,'h55, 0,0,0,0, 0,0, 1,1,0,1));
    tbl.push_back(mk(1,5,'hABCDF, 0,0,0,0, 0,0, 1,0,0,0));

    foreach (tbl[i]) begin
      bus.flush = 0;
      bus.lookup_en = tbl[i].lk;
      bus.lookup_idx = tbl[i].lidx;
      bus.lookup_tag = tbl[i].ltag;
      bus.refill_en = tbl[i].rf;
      bus.refill_idx = tbl[i].ridx;
      bus.refill_way = tbl[i].rway;
      bus.refill_tag = tbl[i].rtag;
      bus.inval_en = tbl[i].iv;
      bus.inval_idx = tbl[i].iidx;
      step();
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d.hit", i), bus.hit, tbl[i].hit);
        chk($sformatf("vec%0d.way", i), bus.hit_way, tbl[i].way);
        chk($sformatf("vec%0d.vic", i), bus.victim_way, tbl[i].vic);
      end
    end
    idle();

    // Flush after a hit: hit drops, everything misses afterwards.
    lk_chk("preflush", 9, 'h55, 1, 0, 1);
    do_flush("flush");
    lk_chk("fl.s5", 5, 'hABCDE, 0, 0, 0);
    lk_chk("fl.s9", 9, 'h55, 0, 0, 0);
    lk_chk("fl.s20", 20, 'h333, 0, 0, 0);
    refill(5, 0, 'hABCDE);
    refill(9, 0, 'h55);
    idle();
    bus.inval_en = 1;
    bus.inval_idx = 5;
    step();
    lk_chk("inv.s5", 5, 'hABCDE, 0, 0, 0);
    lk_chk("inv.s9", 9, 'h55, 1, 0, 1);

    // Stats: 3 hits + 2 misses from a clean reset.
    idle();
    rst = 1;
    step();
    chk("st.rst_hit_cnt", bus.hit_cnt, 0);
    rst = 0;
    wait_ready("st.init");
    refill(5, 0, 'hABCDE);
    refill(9, 1, 'h99);
    lookup(5, 'hABCDE);
    lookup(9, 'h99);
    lookup(5, 'hABCDE);
    lookup(9, 'h1);
    lookup(30, 'h2);
    idle();
    step(); step();
`ifdef ICACHE_TAGV_STATS_EN
    chk("st.hit_cnt", bus.hit_cnt, 3);
    chk("st.miss_cnt", bus.miss_cnt, 2);
    do_flush("st.flush");
    chk("st.flush_hit_cnt", bus.hit_cnt, 3);
    chk("st.flush_miss_cnt", bus.miss_cnt, 2);
    rst = 1;
    step();
    rst = 0;
    chk("st.clr_hit_cnt", bus.hit_cnt, 0);
    chk("st.clr_miss_cnt", bus.miss_cnt, 0);
`else
    chk("st.hit_cnt_off", bus.hit_cnt, 0);
    chk("st.miss_cnt_off", bus.miss_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
